// File: rtl/pc_fetch.sv
// pc_fetch: owns the architectural PC and fetches one instruction at a time.
//
// It issues a single instruction-memory request (valid/ready), waits for the
// single-cycle response pulse, and then presents {pc, instr} downstream under
// a valid/ready handshake. A control-flow redirect can arrive in any state.
// If a redirect makes the in-flight response stale, that response is dropped.
//
// Ports:
//   clk, rst         - clock; synchronous active-high reset
//   imem_req_*       - fetch request: valid/ready, address (= pc)
//   imem_resp_*      - response: valid pulse plus 32-bit instruction word
//   redirect_*       - redirect from execute: valid plus target PC
//   out_*            - downstream handshake with {out_pc, out_instr}
//   fetch_count      - number of instructions accepted downstream (wraps)
module pc_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr,
  output logic [63:0]     fetch_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request at pc is being offered to memory
    S_WAIT = 2'd1,  // exactly one request is outstanding
    S_HOLD = 2'd2   // instruction is presented downstream
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic            drop_reg, drop_next;
  logic [31:0]     instr_reg, instr_next;
  logic [63:0]     count_reg, count_next;

  // Instructions are 4-byte aligned; there is no compressed-instruction
  // support, so the low two bits of a redirect target are forced to zero.
  logic [XLEN-1:0] redirect_target;
  assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_REQ;
      pc_reg    <= RESET_PC;
      drop_reg  <= 1'b0;
      instr_reg <= 32'd0;
      count_reg <= 64'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      drop_reg  <= drop_next;
      instr_reg <= instr_next;
      count_reg <= count_next;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    drop_next  = drop_reg;
    instr_next = instr_reg;
    count_next = count_reg;
    case (state_reg)
      S_REQ: begin
        if (redirect_valid) begin
          pc_next = redirect_target;
          // If the old address was accepted in this cycle, its response
          // is still on its way and must be dropped when it arrives.
          if (imem_req_ready) begin
            state_next = S_WAIT;
            drop_next  = 1'b1;
          end
        end else if (imem_req_ready) begin
          state_next = S_WAIT;
          drop_next  = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          state_next = S_REQ;
          if (redirect_valid) begin
            pc_next   = redirect_target;
            drop_next = 1'b0;
          end else if (drop_reg) begin
            // pc already holds the redirect target.
            drop_next = 1'b0;
          end else begin
            instr_next = imem_resp_data;
            state_next = S_HOLD;
          end
        end else if (redirect_valid) begin
          pc_next   = redirect_target;
          drop_next = 1'b1;
        end
      end
      S_HOLD: begin
        // A redirect cancels the handoff even when downstream is ready.
        if (redirect_valid) begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end else if (out_ready) begin
          pc_next    = pc_reg + XLEN'(4);
          count_next = count_reg + 64'd1;
          state_next = S_REQ;
        end
      end
      default: begin
        state_next = S_REQ;
      end
    endcase
  end

  // Output logic. Handshake outputs are gated by rst so that nothing is
  // offered while reset is held.
  always_comb begin
    imem_req_valid = (state_reg == S_REQ) && !rst;
    out_valid      = (state_reg == S_HOLD) && !rst;
  end

  assign imem_req_addr = pc_reg;
  assign out_pc        = pc_reg;
  assign out_instr     = instr_reg;
  assign fetch_count   = count_reg;

endmodule

// File: tb/tb_pc_fetch.sv
module tb_pc_fetch;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [31:0]     out_instr;
  logic [63:0]     fetch_count;

  int n_cmp;
  int n_err;

  pc_fetch #(
    .XLEN    (XLEN),
    .RESET_PC(64'h0000_0000_8000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs can be sampled and the
  // next cycle's inputs driven away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a request that is accepted at once and answered one cycle later.
  task automatic fetch_to_hold(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_req_valid: got %0b want 0", imem_req_valid);
    end
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_out_valid: got %0b want 0", out_valid);
    end
    n_cmp++;
    if (fetch_count !== 64'd0) begin
      n_err++;
      $display("FAIL reset_count: got %0d want 0", fetch_count);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
      n_err++;
      $display("FAIL reset_first_req: valid %0b addr %h want 1 0000000080000000", imem_req_valid, imem_req_addr);
    end
    $display("test_reset done: req_addr=%h", imem_req_addr);
  endtask

  task automatic test_basic();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_wait: req_valid %0b out_valid %0b want 0 0", imem_req_valid, out_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0413;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_0000 || out_instr !== 32'h0000_0413) begin
      n_err++;
      $display("FAIL basic_present: valid %0b pc %h instr %h want 1 0000000080000000 00000413", out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0004 || fetch_count !== 64'd1) begin
      n_err++;
      $display("FAIL basic_next: req_valid %0b addr %h count %0d want 1 0000000080000004 1", imem_req_valid, imem_req_addr, fetch_count);
    end
    $display("test_basic done: handoff pc=80000000 instr=00000413 count=%0d", fetch_count);
  endtask

  task automatic test_backpressure();
    fetch_to_hold(32'h00a0_0093);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 64'h8000_0004 || out_instr !== 32'h00a0_0093 || imem_req_valid !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: valid %0b pc %h instr %h req %0b want 1 0000000080000004 00a00093 0", i, out_valid, out_pc, out_instr, imem_req_valid);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (fetch_count !== 64'd2 || imem_req_addr !== 64'h8000_0008 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL backpressure_release: count %0d addr %h out_valid %0b want 2 0000000080000008 0", fetch_count, imem_req_addr, out_valid);
    end
    $display("test_backpressure done: count=%0d", fetch_count);
  endtask

  task automatic test_redirect_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_1002;
    tick();
    redirect_valid = 1'b0;
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rwait_pending: out_valid %0b req_valid %0b want 0 0", out_valid, imem_req_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEAD_BEEF;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_1000) begin
      n_err++;
      $display("FAIL rwait_drop: out_valid %0b req %0b addr %h want 0 1 0000000080001000", out_valid, imem_req_valid, imem_req_addr);
    end
    fetch_to_hold(32'h0010_0073);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 64'h8000_1000 || out_instr !== 32'h0010_0073) begin
      n_err++;
      $display("FAIL rwait_present: valid %0b pc %h instr %h want 1 0000000080001000 00100073", out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (fetch_count !== 64'd3 || imem_req_addr !== 64'h8000_1004) begin
      n_err++;
      $display("FAIL rwait_after: count %0d addr %h want 3 0000000080001004", fetch_count, imem_req_addr);
    end
    $display("test_redirect_wait done: count=%0d", fetch_count);
  endtask

  task automatic test_redirect_same_cycle();
    // Redirect together with the request handshake.
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_2000;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rhs_wait: req_valid %0b want 0", imem_req_valid);
    end
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h1111_1111;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_2000 || fetch_count !== 64'd3) begin
      n_err++;
      $display("FAIL rhs_drop: out_valid %0b req %0b addr %h count %0d want 0 1 0000000080002000 3", out_valid, imem_req_valid, imem_req_addr, fetch_count);
    end
    // Redirect together with the response.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h2222_2222;
    redirect_valid  = 1'b1;
    redirect_pc     = 64'h8000_3000;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_3000 || fetch_count !== 64'd3) begin
      n_err++;
      $display("FAIL rresp_drop: out_valid %0b req %0b addr %h count %0d want 0 1 0000000080003000 3", out_valid, imem_req_valid, imem_req_addr, fetch_count);
    end
    $display("test_redirect_same_cycle done: addr=%h", imem_req_addr);
  endtask

  task automatic test_redirect_hold();
    fetch_to_hold(32'h3333_3333);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_4000;
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || fetch_count !== 64'd3 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_4000) begin
      n_err++;
      $display("FAIL rhold: out_valid %0b count %0d req %0b addr %h want 0 3 1 0000000080004000", out_valid, fetch_count, imem_req_valid, imem_req_addr);
    end
    $display("test_redirect_hold done: addr=%h", imem_req_addr);
  endtask

  task automatic test_reset_in_wait();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    n_cmp++;
    if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait_held: req %0b out_valid %0b want 0 0", imem_req_valid, out_valid);
    end
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBADB_AD00;
    tick();
    imem_resp_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000 || fetch_count !== 64'd0) begin
      n_err++;
      $display("FAIL rst_wait_reissue: out_valid %0b req %0b addr %h count %0d want 0 1 0000000080000000 0", out_valid, imem_req_valid, imem_req_addr, fetch_count);
    end
    $display("test_reset_in_wait done: addr=%h", imem_req_addr);
  endtask

  task automatic test_pc_wrap();
    // Low two bits of the target are ignored.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    n_cmp++;
    if (imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC || imem_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_target: addr %h req %0b want fffffffffffffffc 1", imem_req_addr, imem_req_valid);
    end
    fetch_to_hold(32'h4444_4444);
    n_cmp++;
    if (out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_instr !== 32'h4444_4444) begin
      n_err++;
      $display("FAIL wrap_present: pc %h instr %h want fffffffffffffffc 44444444", out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (imem_req_addr !== 64'h0 || fetch_count !== 64'd1) begin
      n_err++;
      $display("FAIL wrap_next: addr %h count %0d want 0000000000000000 1", imem_req_addr, fetch_count);
    end
    $display("test_pc_wrap done: addr=%h count=%0d", imem_req_addr, fetch_count);
  endtask

  task automatic test_back_to_back();
    // Request is offered the cycle after a handoff: at most one per 3 cycles.
    fetch_to_hold(32'h5555_5555);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h4) begin
      n_err++;
      $display("FAIL b2b_req: req %0b addr %h want 1 0000000000000004", imem_req_valid, imem_req_addr);
    end
    fetch_to_hold(32'h6666_6666);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 64'h4 || out_instr !== 32'h6666_6666) begin
      n_err++;
      $display("FAIL b2b_present: valid %0b pc %h instr %h want 1 0000000000000004 66666666", out_valid, out_pc, out_instr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++;
    if (fetch_count !== 64'd3 || imem_req_addr !== 64'h8) begin
      n_err++;
      $display("FAIL b2b_count: count %0d addr %h want 3 0000000000000008", fetch_count, imem_req_addr);
    end
    $display("test_back_to_back done: count=%0d", fetch_count);
  endtask

  initial begin
    n_cmp           = 0;
    n_err           = 0;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    out_ready       = 1'b0;

    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_hold();
    test_reset_in_wait();
    test_pc_wrap();
    test_back_to_back();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_fetch.md
Name: pc_fetch

Overview:
Upstream neighbour of the instruction-fetch decode slicer. Owns the architectural PC and issues one instruction-memory request at a time over a valid/ready request plus valid-only response interface. Captures the returned 32-bit instruction and presents {pc, instr} to the downstream stage (its PCAddr/instr inputs) under a valid/ready handshake. Branch/jump redirects from execute can arrive at any point; an in-flight response made stale by a redirect is discarded.

Parameters:
RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset
XLEN, 64, PC/address width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  request address (= pc register)
imem_resp_valid  input  1  response data valid, single-cycle pulse
imem_resp_data  input  32  returned instruction word
redirect_valid  input  1  control-flow redirect this cycle
redirect_pc  input  XLEN  redirect target
out_valid  output  1  {out_pc, out_instr} valid for downstream
out_ready  input  1  downstream accepts
out_pc  output  XLEN  PC of presented instruction
out_instr  output  32  presented instruction
fetch_count  output  64  count of instructions handed downstream

Behaviour:
- Registers: pc, state {REQ, WAIT, HOLD}, drop flag, instr_q, fetch_count.
- Reset (rst=1 at edge): pc<=RESET_PC, state<=REQ, drop<=0, instr_q<=0, fetch_count<=0. While rst=1: imem_req_valid=0, out_valid=0. Reset mid-operation abandons any outstanding request; a response arriving afterwards in REQ is ignored.
- imem_req_valid = (state==REQ) && !rst. imem_req_addr = pc. out_valid = (state==HOLD). out_pc = pc. out_instr = instr_q. Both out_pc and out_instr are stable while out_valid=1.
- pc[1:0] is always 0: redirect_pc[1:0] is ignored (written as 2'b00). No compressed-instruction support.
- REQ:
  - redirect_valid and handshake fires the same cycle: pc<=redirect_pc, drop<=1, go to WAIT.
  - redirect_valid only: pc<=redirect_pc, stay in REQ.
  - Handshake only (req_valid && req_ready): go to WAIT, drop<=0.
  - Otherwise hold.
- WAIT (exactly one outstanding request):
  - imem_resp_valid and redirect_valid together: response discarded, pc<=redirect_pc, drop<=0, go to REQ.
  - imem_resp_valid with drop=1: discard, drop<=0, go to REQ (pc already holds the redirect target).
  - imem_resp_valid with drop=0: instr_q<=imem_resp_data, go to HOLD.
  - redirect_valid only: pc<=redirect_pc, drop<=1, stay in WAIT.
- HOLD:
  - redirect_valid (has priority over out_ready): pc<=redirect_pc, go to REQ. No fetch_count increment.
  - out_ready: pc<=pc+4 (XLEN wrap-around, no overflow flag), fetch_count<=fetch_count+1 (wraps), go to REQ.
- imem_resp_valid in REQ or HOLD is a protocol violation and is ignored.
- Latency with ready=1 and a 1-cycle memory: request in cycle N, response in N+1, out_valid in N+2. Next request no earlier than N+3 (at most one instruction per 3 cycles).

Test Plan:
- Reset release, imem_req_ready=1, response in the cycle after the request returns 32'h00000413, out_ready=1 -> imem_req_addr=0x80000000; out_valid 2 cycles after the request with out_pc=0x80000000, out_instr=0x00000413; next request addr=0x80000004; fetch_count=1.
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_valid stays 1, out_pc/out_instr stable, no new imem request. Then out_ready=1 -> fetch_count increments by exactly 1.
- Redirect during WAIT to 0x80001002, stale response 32'hDEADBEEF arrives 2 cycles later -> no out_valid; next request addr=0x80001000; following response is presented with out_pc=0x80001000.
- Redirect in the same cycle as the request handshake, and separately in the same cycle as imem_resp_valid -> response dropped; next request addr = redirect target; fetch_count unchanged.
- Redirect in HOLD with out_ready=1 the same cycle -> no handoff, fetch_count unchanged, next request addr = redirect target.
- rst asserted in WAIT, response arrives after rst deasserts -> ignored; request reissued at 0x80000000. pc wrap: redirect to 0xFFFFFFFFFFFFFFFC, handoff -> next addr=0x0.
